// File: rtl/alu_pkg.sv
// Shared opcodes and sequencer state encoding for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: combinational, no state; SUB inverts B internally and
// relies on the caller to feed carryin=1 into bit 0.
module alu1
  import alu_pkg::*;
(
  output logic       out,
  output logic       carryout,
  input  logic       A,
  input  logic       B,
  input  logic       carryin,
  input  logic [2:0] control
);

  logic b_eff;
  logic sum;

  always_comb begin
    b_eff    = B ^ (control == ALU_SUB);
    sum      = A ^ b_eff ^ carryin;
    carryout = (A & b_eff) | (carryin & (A ^ b_eff));
    out      = 1'b0;
    case (control)
      ALU_ADD, ALU_SUB: out = sum;
      ALU_AND:          out = A & B;
      ALU_OR:           out = A | B;
      ALU_NOR:          out = ~(A | B);
      ALU_XOR:          out = A ^ B;
      default:          out = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu1_serial_sequencer.sv
// Runs one alu1 slice LSB-first over W cycles; done pulses in FINISH, W+2 cycles per op.
// start is only looked at in IDLE; requests arriving while busy or in FINISH are dropped.
module alu1_serial_sequencer
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   control,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carryout,
  output logic         overflow,
  output logic         zero,
  output logic         illegal
);

  localparam int CW = $clog2(W) + 1;

  seq_state_t     state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic [2:0]     op_q, op_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [W-1:0]   result_q, result_d;
  logic           carryout_q, carryout_d, overflow_q, overflow_d;
  logic           zero_q, zero_d, illegal_q, illegal_d;

  logic           slice_out, slice_cout;
  logic [W-1:0]   res_next;
  logic           arith;

  alu1 u_slice (
    .out      (slice_out),
    .carryout (slice_cout),
    .A        (a_sh_q[0]),
    .B        (b_sh_q[0]),
    .carryin  (carry_q),
    .control  (op_q)
  );

  assign res_next = {slice_out, res_sh_q[W-1:1]};
  assign arith    = is_arith(op_q);

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    op_d       = op_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (control[2] | control[1]) begin
            a_sh_d    = a;
            b_sh_d    = b;
            op_d      = control;
            carry_d   = (control == ALU_SUB);
            cnt_d     = '0;
            busy_d    = 1'b1;
            illegal_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            illegal_d  = 1'b1;
            result_d   = '0;
            carryout_d = 1'b0;
            overflow_d = 1'b0;
            zero_d     = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_FINISH;
          end
        end
      end
      ST_RUN: begin
        res_sh_d = res_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = arith & slice_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // carry_q here is the carry into the MSB, so it pairs with slice_cout for overflow
          result_d   = res_next;
          carryout_d = arith & slice_cout;
          overflow_d = arith & (carry_q ^ slice_cout);
          zero_d     = (res_next == '0);
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign illegal  = illegal_q;

endmodule
